// File: rtl/dmem_responder.sv
// Word-addressed data memory with a ready handshake and configurable read latency.
// Optional byte-lane writes are enabled by defining DMEM_BYTE_WRITE_EN.
module dmem_responder #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd,
    input  logic                i_wr,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [DATA_W-1:0]   i_wr_data,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] i_be,
`endif
    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_ready,
    output logic                o_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic [ADDR_W-1:0]   r_addr, w_addr_d;
    logic [DATA_W-1:0]   r_rd_data, w_rd_data_d;
    logic                r_err, w_err_d;

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_req_in_range;
    logic                w_lat_in_range;
    logic                w_mem_we;
    logic [IDX_W-1:0]    w_rd_idx;
    logic [DATA_W-1:0]   w_mem_rdata;

    assign w_req_in_range = ({1'b0, i_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_lat_in_range = ({1'b0, r_addr} < (ADDR_W + 1)'(DEPTH));

    // Completing reads in WAIT use the latched address, so bus changes there are ignored.
    assign w_rd_idx    = (r_state == StWait) ? r_addr[IDX_W-1:0] : i_addr[IDX_W-1:0];
    assign w_mem_rdata = r_mem[w_rd_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_addr    <= w_addr_d;
            r_rd_data <= w_rd_data_d;
            r_err     <= w_err_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_addr_d    = r_addr;
        w_rd_data_d = r_rd_data;
        w_err_d     = r_err;
        w_mem_we    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_rd && i_wr) begin
                    w_err_d   = 1'b1;
                    w_state_d = StResp;
                end else if (i_wr) begin
                    w_mem_we  = w_req_in_range;
                    w_err_d   = !w_req_in_range;
                    w_state_d = StResp;
                end else if (i_rd) begin
                    if (RD_LATENCY == 1) begin
                        w_rd_data_d = w_req_in_range ? w_mem_rdata : '0;
                        w_err_d     = !w_req_in_range;
                        w_state_d   = StResp;
                    end else begin
                        w_cnt_d   = CNT_W'(RD_LATENCY - 1);
                        w_addr_d  = i_addr;
                        w_state_d = StWait;
                    end
                end
            end
            StWait: begin
                w_cnt_d = r_cnt - 1'b1;
                if (r_cnt <= CNT_W'(1)) begin
                    w_rd_data_d = w_lat_in_range ? w_mem_rdata : '0;
                    w_err_d     = !w_lat_in_range;
                    w_state_d   = StResp;
                end
            end
            StResp: begin
                w_err_d   = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Storage has no reset: contents are undefined at power-up and survive reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
`ifdef DMEM_BYTE_WRITE_EN
            for (int i = 0; i < int'(DATA_W / 8); i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr[IDX_W-1:0]][8*i +: 8] <= i_wr_data[8*i +: 8];
                end
            end
`else
            r_mem[i_addr[IDX_W-1:0]] <= i_wr_data;
`endif
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_ready   = (r_state == StResp);
    assign o_err     = (r_state == StResp) && r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=256, RD_LATENCY=2).
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        err;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]  be;
`endif

    int n_total;
    int n_bad;

    dmem_responder #(
        .ADDR_W     (9),
        .DATA_W     (32),
        .DEPTH      (256),
        .RD_LATENCY (2)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_rd      (rd),
        .i_wr      (wr),
        .i_addr    (addr),
        .i_wr_data (wr_data),
`ifdef DMEM_BYTE_WRITE_EN
        .i_be      (be),
`endif
        .o_rd_data (rd_data),
        .o_ready   (ready),
        .o_err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input string tag, input logic [8:0] a, input logic [31:0] d,
                            input logic exp_err);
        wr      = 1'b1;
        addr    = a;
        wr_data = d;
        step();
        check_val({tag, " ready"}, 32'(ready), 32'd1);
        check_val({tag, " err"}, 32'(err), 32'(exp_err));
        wr = 1'b0;
        step();
        check_val({tag, " ready drop"}, 32'(ready), 32'd0);
    endtask

    // Scrambles addr after acceptance to show the latched address is used.
    task automatic do_read(input string tag, input logic [8:0] a, input logic [31:0] exp_d,
                           input logic exp_err);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        rd   = 1'b1;
        addr = a;
        for (int i = 1; i <= 8 && !seen; i++) begin
            step();
            if (i == 1) addr = a ^ 9'h1FF;
            if (ready) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        rd = 1'b0;
        check_val({tag, " latency"}, 32'(lat), 32'd2);
        check_val({tag, " data"}, rd_data, exp_d);
        check_val({tag, " err"}, 32'(err), 32'(exp_err));
        step();
        check_val({tag, " ready drop"}, 32'(ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = '0;
        wr_data = '0;
`ifdef DMEM_BYTE_WRITE_EN
        be      = 4'hF;
`endif

        // Reset held two cycles, then ten idle cycles.
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val("rst ready", 32'(ready), 32'd0);
            check_val("rst err", 32'(err), 32'd0);
            check_val("rst rd_data", rd_data, 32'd0);
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("idle ready", 32'(ready), 32'd0);
            check_val("idle err", 32'(err), 32'd0);
            check_val("idle rd_data", rd_data, 32'd0);
        end

        // Write then read back.
        do_write("wr5", 9'd5, 32'hDEADBEEF, 1'b0);
        do_read("rd5", 9'd5, 32'hDEADBEEF, 1'b0);

        // Rd/wr conflict leaves memory and rd_data alone.
        do_write("wr7", 9'd7, 32'h12345678, 1'b0);
        rd      = 1'b1;
        wr      = 1'b1;
        addr    = 9'd7;
        wr_data = 32'h0BADF00D;
        step();
        check_val("conflict ready", 32'(ready), 32'd1);
        check_val("conflict err", 32'(err), 32'd1);
        check_val("conflict rd_data", rd_data, 32'hDEADBEEF);
        rd = 1'b0;
        wr = 1'b0;
        step();
        check_val("conflict err drop", 32'(err), 32'd0);
        do_read("rd7", 9'd7, 32'h12345678, 1'b0);

        // Out of range: read yields 0 with err, write dropped without aliasing.
        do_write("wr44", 9'd44, 32'h0000CAFE, 1'b0);
        do_read("rd300", 9'd300, 32'h0, 1'b1);
        do_write("wr300", 9'd300, 32'h00000BAD, 1'b1);
        do_read("rd44", 9'd44, 32'h0000CAFE, 1'b0);

        // Reset during WAIT aborts the read without a ready pulse.
        rd   = 1'b1;
        addr = 9'd5;
        step();
        rst_n = 1'b0;
        rd    = 1'b0;
        #1;
        check_val("midrst ready", 32'(ready), 32'd0);
        check_val("midrst rd_data", rd_data, 32'd0);
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ready) pulses++;
        end
        check_val("midrst no ready", 32'(pulses), 32'd0);
        do_read("rd5 after rst", 9'd5, 32'hDEADBEEF, 1'b0);

        // Held write: a request is re-sampled every other cycle.
        wr      = 1'b1;
        addr    = 9'd9;
        wr_data = 32'h11;
        pulses  = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("held ready", 32'(ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (ready) pulses++;
        end
        wr = 1'b0;
        check_val("held pulses", 32'(pulses), 32'd2);
        do_read("rd9", 9'd9, 32'h11, 1'b0);

`ifdef DMEM_BYTE_WRITE_EN
        be = 4'hF;
        do_write("be full", 9'd3, 32'hAABBCCDD, 1'b0);
        be = 4'b0101;
        do_write("be 0101", 9'd3, 32'h11223344, 1'b0);
        do_read("rd3 lanes", 9'd3, 32'hAA22CC44, 1'b0);
        be = 4'b0000;
        do_write("be none", 9'd3, 32'hFFFFFFFF, 1'b0);
        do_read("rd3 keep", 9'd3, 32'hAA22CC44, 1'b0);
        be = 4'hF;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data memory that answers the core's load/store port (`rd`, `wr`, `addr`, `wr_data`, `rd_data`). It is the responder for the memory-stage requests the `riscv` core issues. It adds a `ready` handshake with a configurable read latency so the pipeline can be tested against a non-zero-wait memory. It sits beside the core in the top-level test harness and replaces the ideal zero-latency memory.

## Interface
- `ADDR_W`, 9: word address width.
- `DATA_W`, 32: data word width.
- `DEPTH`, 512: implemented words, must be ≤ 2^ADDR_W.
- `RD_LATENCY`, 2: cycles from read acceptance to `ready`, must be ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs.
- `rd` in 1: read request; held by the core until `ready`.
- `wr` in 1: write request; held by the core until `ready`.
- `addr` in ADDR_W: word address; stable while the request is held.
- `wr_data` in DATA_W: store data; stable while `wr` is held.
- `rd_data` out DATA_W: load data; valid in the `ready` cycle of a read, held afterwards.
- `ready` out 1: one-cycle completion pulse for the accepted request.
- `err` out 1: one-cycle pulse coincident with `ready` for a failed request.

## Operation
- FSM states:
  - IDLE: sample requests.
  - WAIT: read latency countdown.
  - RESP: drive `ready`.
- Transitions from IDLE:
  - `wr && !rd`: commit `mem[addr] <= wr_data` at that edge, then go to RESP.
  - `rd && !wr`, RD_LATENCY == 1: latch `mem[addr]` into `rd_data`, then go to RESP.
  - `rd && !wr`, RD_LATENCY > 1: load the counter with RD_LATENCY-1 and latch `addr`, then go to WAIT.
  - `rd && wr`: protocol error. No memory access, `rd_data` unchanged, go to RESP with `err` flagged.
  - Neither request: stay in IDLE.
- WAIT: decrement the counter. At 1, latch `mem[addr_latched]` into `rd_data` and go to RESP.
- RESP: `ready`=1 (and `err` if flagged) for exactly one cycle, then return to IDLE. Requests are not sampled in RESP.
- Out of range (`addr >= DEPTH`): the write is dropped, a read returns 0, and `err` pulses with `ready`. The handshake timing is unchanged.
- Memory contents are not reset; their power-up values are undefined.

## Timing
- Reset values: `ready`=0, `err`=0, `rd_data`=0, state IDLE, counter 0.
- Write accepted in cycle T: memory updated at the end of T, `ready`=1 in T+1.
- Read accepted in cycle T: `ready`=1 and `rd_data` valid in T+RD_LATENCY.
- A request still asserted in the cycle after `ready` is a new request. The core must drop `rd`/`wr` in the `ready` cycle to avoid a repeat.
- Back-to-back operations:
  - Minimum write-to-write spacing is 2 cycles.
  - Read-after-write to the same address returns the new data.
- Reset mid-operation (WAIT or RESP):
  - Return to IDLE immediately.
  - No `ready` is produced for the aborted request.
  - A write committed before reset stays in memory.
- `addr`/`wr_data` changes during WAIT are ignored because the address is latched.

## Configuration
- `DMEM_BYTE_WRITE_EN` defined:
  - Adds input `be` [DATA_W/8], byte enables sampled with `wr`.
  - Only lanes with `be[i]`=1 are written; other bytes keep their old value.
  - `be`=0 still completes with `ready` and no change.
  - Reads ignore `be`.
- Not defined: no `be` port, and every write updates the full word.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, release, no requests for 10 cycles → `ready`, `err`, `rd_data` all 0 throughout.
- Write then read: write 0xDEADBEEF to addr 5 at T → `ready` at T+1. Read addr 5 at T+3 with RD_LATENCY=2 → `ready` at T+5, `rd_data`=0xDEADBEEF.
- Conflict and range: `rd`=`wr`=1, addr 7 → `ready`=`err`=1 one cycle later, mem[7] unchanged. With DEPTH=256, read addr 300 → `rd_data`=0 and `err`=1.
- Reset mid-read: start a read of addr 5, assert `reset` in WAIT → no `ready`, `rd_data`=0. A later read of addr 5 still returns 0xDEADBEEF.
- Held request: keep `wr` high for 4 cycles, addr 9, data 0x11 → two `ready` pulses spaced 2 cycles apart, mem[9]=0x11.
- Byte enables (`DMEM_BYTE_WRITE_EN`): mem[3]=0xAABBCCDD, write 0x11223344 with `be`=4'b0101 → read returns 0xAA22CC44.
